zturbo_ctrl: RTL and testbench



---
 rtl/zclk_pkg.sv | 25 ++
 rtl/zwait_gen.sv | 81 ++++++++
 rtl/zturbo_ctrl.sv | 131 +++++++++++++
 tb/tb_zturbo_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zclk_pkg.sv
// Shared definitions for the Z80 clock-generator turbo sequencer and stall generator.
package zclk_pkg;

  // Turbo encodings as seen by the clock generator
  localparam logic [1:0] TURBO_3M5 = 2'b00;
  localparam logic [1:0] TURBO_7M  = 2'b01;
  localparam logic [1:0] TURBO_14M = 2'b10;

  // Default timing parameters
  localparam int DWELL_CYC_DEF = 16;
  localparam int WAIT_MAX_DEF  = 7;

  // Turbo sequencer states
  typedef enum logic [1:0] {
    STABLE = 2'd0,
    PEND   = 2'd1,
    DWELL  = 2'd2
  } seq_state_e;

  // Fold the unused 11 encoding onto 14 MHz
  function automatic logic [1:0] norm_turbo(input logic [1:0] v);
    return v[1] ? TURBO_14M : v;
  endfunction

endpackage

// File: rtl/zwait_gen.sv
// Stall generator: asserts zstall when a CPU memory cycle collides with a
// video fetch at 14 MHz, releasing on !vid_busy or after WAIT_MAX+1 cycles.
// Optional statistics counters under ZTURBO_STAT_EN.
module zwait_gen
  import zclk_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic        fclk,
  input  logic        rst,
  input  logic        arm,
  input  logic        cpu_mreq_start,
  input  logic        vid_busy,
`ifdef ZTURBO_STAT_EN
  input  logic        stat_clr,
  output logic [15:0] stat_stall,
  output logic [7:0]  stat_to,
`endif
  output logic        zstall,
  output logic        stall_to
);

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

  logic       zstall_q;
  logic       to_q;
  logic [3:0] wcnt_q;

  // Stall set/hold/release; new requests are ignored while a stall is active
  always_ff @(posedge fclk) begin
    if (rst) begin
      zstall_q <= 1'b0;
      to_q     <= 1'b0;
      wcnt_q   <= 4'd0;
    end else if (!zstall_q) begin
      to_q <= 1'b0;
      if (arm && cpu_mreq_start && vid_busy) begin
        zstall_q <= 1'b1;
        wcnt_q   <= 4'd0;
      end
    end else begin
      wcnt_q <= wcnt_q + 4'd1;
      if (!vid_busy) begin
        zstall_q <= 1'b0;
        to_q     <= 1'b0;
      end else if (wcnt_q == WAIT_LIM) begin
        zstall_q <= 1'b0;
        to_q     <= 1'b1;
      end else begin
        to_q <= 1'b0;
      end
    end
  end

  assign zstall   = zstall_q;
  assign stall_to = to_q;

`ifdef ZTURBO_STAT_EN
  logic [15:0] stat_stall_q;
  logic [7:0]  stat_to_q;

  // Saturating counts of stalled cycles and timeout releases
  always_ff @(posedge fclk) begin
    if (rst || stat_clr) begin
      stat_stall_q <= 16'd0;
      stat_to_q    <= 8'd0;
    end else begin
      if (zstall_q && (stat_stall_q != 16'hFFFF)) begin
        stat_stall_q <= stat_stall_q + 16'd1;
      end
      if (to_q && (stat_to_q != 8'hFF)) begin
        stat_to_q <= stat_to_q + 8'd1;
      end
    end
  end

  assign stat_stall = stat_stall_q;
  assign stat_to    = stat_to_q;
`endif

endmodule

// File: rtl/zturbo_ctrl.sv
// Turbo sequencer for the Z80 clock generator: arbitrates CPU turbo setting
// against force_slow, changes only on half_cend boundaries with a dwell
// between changes, and hosts the 14 MHz stall generator (zwait_gen).
// Optional macro ZTURBO_STAT_EN adds stall statistics ports.
module zturbo_ctrl
  import zclk_pkg::*;
#(
  parameter int DWELL_CYC = DWELL_CYC_DEF,
  parameter int WAIT_MAX  = WAIT_MAX_DEF
) (
  input  logic        fclk,
  input  logic        rst,
  input  logic        pre_cend,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_turbo,
  input  logic        force_slow,
  input  logic        cpu_mreq_start,
  input  logic        vid_busy,
`ifdef ZTURBO_STAT_EN
  input  logic        stat_clr,
  output logic [15:0] stat_stall,
  output logic [7:0]  stat_to,
`endif
  output logic [1:0]  turbo_out,
  output logic        turbo_chg,
  output logic        zstall,
  output logic        stall_to
);

  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYC - 1);

  logic       phase_q;
  logic [1:0] cfg_q;
  logic [1:0] turbo_q;
  logic       chg_q;
  logic [7:0] dwell_q;
  seq_state_e state_q;

  logic       half_cend;
  logic [1:0] tgt;

  // Boundary detect and requested target (force_slow wins over the CPU setting)
  always_comb begin
    half_cend = pre_cend & phase_q;
    if (force_slow) begin
      tgt = TURBO_3M5;
    end else begin
      tgt = cfg_q;
    end
  end

  // Phase tracker aligned with the clock generator, and the CPU turbo register
  always_ff @(posedge fclk) begin
    if (rst) begin
      phase_q <= 1'b0;
      cfg_q   <= TURBO_3M5;
    end else begin
      if (pre_cend) begin
        phase_q <= ~phase_q;
      end
      if (cfg_we) begin
        cfg_q <= norm_turbo(cfg_turbo);
      end
    end
  end

  // Turbo sequencer FSM with registered turbo_out / turbo_chg
  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q <= STABLE;
      turbo_q <= TURBO_3M5;
      chg_q   <= 1'b0;
      dwell_q <= 8'd0;
    end else begin
      chg_q <= 1'b0;
      case (state_q)
        STABLE: begin
          if (tgt != turbo_q) begin
            state_q <= PEND;
          end
        end
        PEND: begin
          if (tgt == turbo_q) begin
            state_q <= STABLE;
          end else if (half_cend) begin
            turbo_q <= tgt;
            chg_q   <= 1'b1;
            dwell_q <= DWELL_LOAD;
            state_q <= DWELL;
          end
        end
        DWELL: begin
          // Slowing down for force_slow never waits out the dwell
          if (force_slow && (turbo_q != TURBO_3M5)) begin
            state_q <= PEND;
          end else if (half_cend) begin
            if (dwell_q == 8'd0) begin
              state_q <= STABLE;
            end else begin
              dwell_q <= dwell_q - 8'd1;
            end
          end
        end
        default: begin
          state_q <= STABLE;
        end
      endcase
    end
  end

  assign turbo_out = turbo_q;
  assign turbo_chg = chg_q;

  zwait_gen #(
    .WAIT_MAX(WAIT_MAX)
  ) u_zwait_gen (
    .fclk          (fclk),
    .rst           (rst),
    .arm           (turbo_q[1]),
    .cpu_mreq_start(cpu_mreq_start),
    .vid_busy      (vid_busy),
`ifdef ZTURBO_STAT_EN
    .stat_clr      (stat_clr),
    .stat_stall    (stat_stall),
    .stat_to       (stat_to),
`endif
    .zstall        (zstall),
    .stall_to      (stall_to)
  );

endmodule

// File: tb/tb_zturbo_ctrl.sv
// Self-checking bench for zturbo_ctrl: directed sequences, a per-cycle
// vector table for the stall generator, and randomized traffic checked
// against a behavioural model.
module tb_zturbo_ctrl;

  localparam int DWELL = 16;
  localparam int WMAX  = 7;

  logic        fclk = 1'b0;
  logic        rst = 1'b1;
  logic        pre_cend = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_turbo = 2'b00;
  logic        force_slow = 1'b0;
  logic        cpu_mreq_start = 1'b0;
  logic        vid_busy = 1'b0;
  logic        stat_clr = 1'b0;
  logic [15:0] stat_stall;
  logic [7:0]  stat_to;
  logic [1:0]  turbo_out;
  logic        turbo_chg;
  logic        zstall;
  logic        stall_to;

  int n_cmp = 0;
  int n_bad = 0;
  int chg_seen = 0;

  always #5 fclk = ~fclk;

  zturbo_ctrl #(.DWELL_CYC(DWELL), .WAIT_MAX(WMAX)) dut (
    .fclk          (fclk),
    .rst           (rst),
    .pre_cend      (pre_cend),
    .cfg_we        (cfg_we),
    .cfg_turbo     (cfg_turbo),
    .force_slow    (force_slow),
    .cpu_mreq_start(cpu_mreq_start),
    .vid_busy      (vid_busy),
`ifdef ZTURBO_STAT_EN
    .stat_clr      (stat_clr),
    .stat_stall    (stat_stall),
    .stat_to       (stat_to),
`endif
    .turbo_out     (turbo_out),
    .turbo_chg     (turbo_chg),
    .zstall        (zstall),
    .stall_to      (stall_to)
  );

`ifndef ZTURBO_STAT_EN
  assign stat_stall = 16'd0;
  assign stat_to    = 8'd0;
`endif

  // ---------------- behavioural reference model ----------------
  // Sequencer: a change fires on a half_cend once the mismatch has been seen
  // for a full cycle while eligible; eligibility = 16 half_cends since the
  // last change, or a pending slow-down request.
  logic [1:0] m_turbo, m_cfg;
  bit m_chg, m_zs, m_to, m_armed, m_pre_odd;
  int m_hc_since, m_high_cycles, m_st_stall, m_st_to;

  task automatic model_step();
    bit half, mismatch, changed, eligible;
    logic [1:0] tgt;
    if (rst) begin
      m_turbo = 2'b00; m_cfg = 2'b00; m_chg = 0; m_zs = 0; m_to = 0;
      m_armed = 0; m_pre_odd = 0; m_hc_since = DWELL; m_high_cycles = 0;
      m_st_stall = 0; m_st_to = 0;
      return;
    end
    // statistics see the outputs as they were during this cycle
    if (stat_clr) begin
      m_st_stall = 0; m_st_to = 0;
    end else begin
      if (m_zs && m_st_stall < 65535) m_st_stall++;
      if (m_to && m_st_to < 255) m_st_to++;
    end
    // stall: at most WMAX+1 cycles high, ends early when video lets go
    if (!m_zs) begin
      m_to = 0;
      if (m_turbo[1] && cpu_mreq_start && vid_busy) begin
        m_zs = 1; m_high_cycles = 0;
      end
    end else begin
      m_high_cycles++;
      m_to = 0;
      if (!vid_busy) m_zs = 0;
      else if (m_high_cycles == WMAX + 1) begin m_zs = 0; m_to = 1; end
    end
    // sequencer
    half     = pre_cend && m_pre_odd;
    tgt      = force_slow ? 2'b00 : m_cfg;
    mismatch = (tgt != m_turbo);
    changed  = m_armed && mismatch && half;
    eligible = (m_hc_since >= DWELL) || (force_slow && m_turbo != 2'b00) || m_armed;
    if (m_armed && !mismatch) m_hc_since = DWELL;   // cancelled request forgets dwell
    m_armed = mismatch && !changed && eligible;
    if (changed) begin
      m_turbo = tgt; m_chg = 1; m_hc_since = 0;
    end else begin
      m_chg = 0;
      if (half && m_hc_since < DWELL) m_hc_since++;
    end
    if (cfg_we) m_cfg = cfg_turbo[1] ? 2'b10 : cfg_turbo;
    if (pre_cend) m_pre_odd = !m_pre_odd;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock: advance model, clock DUT, compare every output to the model
  task automatic tick();
    model_step();
    @(posedge fclk);
    #1;
    if (turbo_chg === 1'b1) chg_seen++;
    chk("m_turbo_out", {30'd0, turbo_out}, {30'd0, m_turbo});
    chk("m_turbo_chg", {31'd0, turbo_chg}, {31'd0, m_chg});
    chk("m_zstall",    {31'd0, zstall},    {31'd0, m_zs});
    chk("m_stall_to",  {31'd0, stall_to},  {31'd0, m_to});
`ifdef ZTURBO_STAT_EN
    chk("m_stat_stall", {16'd0, stat_stall}, m_st_stall);
    chk("m_stat_to",    {24'd0, stat_to},    m_st_to);
`endif
  endtask

  task automatic pc(input int n);
    for (int k = 0; k < n; k++) begin
      pre_cend = 1'b1; tick();
      pre_cend = 1'b0; tick();
    end
  endtask

  task automatic hc(input int n);
    pc(2 * n);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic write_cfg(input logic [1:0] v);
    cfg_we = 1'b1; cfg_turbo = v; tick(); cfg_we = 1'b0; cfg_turbo = 2'b00;
  endtask

  typedef struct {
    logic start; logic vid; logic clr; logic exp_zs; logic exp_to;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic s, input logic v, input logic c,
                              input logic z, input logic t);
    vec_t r;
    r.start = s; r.vid = v; r.clr = c; r.exp_zs = z; r.exp_to = t;
    tbl.push_back(r);
  endfunction

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      cpu_mreq_start = tbl[i].start; vid_busy = tbl[i].vid; stat_clr = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d_zstall", i), {31'd0, zstall}, {31'd0, tbl[i].exp_zs});
      chk($sformatf("vec%0d_stall_to", i), {31'd0, stall_to}, {31'd0, tbl[i].exp_to});
    end
    cpu_mreq_start = 1'b0; vid_busy = 1'b0; stat_clr = 1'b0;
  endtask

  int c0, seg_a, seg_b, seg_c, seg_d;

  initial begin
    // stall vectors (14 MHz): 3-cycle collision, then clear, then two timeouts
    add(1,1,0,1,0); add(0,1,0,1,0); add(0,1,0,1,0); add(0,0,0,0,0); add(0,0,0,0,0);
    seg_a = tbl.size();
    add(0,0,1,0,0);
    for (int r = 0; r < 2; r++) begin
      add(1,1,0,1,0);
      for (int k = 1; k <= 7; k++) add((k == 3) ? 1'b1 : 1'b0, 1, 0, 1, 0);
      add(0,1,0,0,1); add(0,1,0,0,0); add(0,0,0,0,0);
    end
    seg_b = tbl.size();
    add(0,0,1,0,0);
    seg_c = tbl.size();
    // 7 MHz: collisions never stall
    add(1,1,0,0,0); add(0,1,0,0,0); add(1,1,0,0,0); add(0,1,0,0,0);
    seg_d = tbl.size();

    // reset state
    do_reset();
    chk("rst_turbo_out", {30'd0, turbo_out}, 32'd0);
    chk("rst_turbo_chg", {31'd0, turbo_chg}, 32'd0);
    chk("rst_zstall",    {31'd0, zstall},    32'd0);
    chk("rst_stall_to",  {31'd0, stall_to},  32'd0);

    // 3.5 -> 7 MHz on the first half_cend
    write_cfg(2'b01);
    pc(1);
    chk("t1_before_half", {30'd0, turbo_out}, 32'd0);
    pre_cend = 1'b1; tick();
    chk("t1_change", {30'd0, turbo_out}, 32'd1);
    chk("t1_chg_pulse", {31'd0, turbo_chg}, 32'd1);
    pre_cend = 1'b0; tick();
    chk("t1_chg_once", {31'd0, turbo_chg}, 32'd0);

    // request 14 MHz (as 11) during dwell: held for 16 half_cends
    write_cfg(2'b11);
    c0 = chg_seen;
    hc(DWELL);
    chk("t2_dwell_hold", {30'd0, turbo_out}, 32'd1);
    chk("t2_no_chg", chg_seen - c0, 32'd0);
    hc(1);
    chk("t2_after_dwell", {30'd0, turbo_out}, 32'd2);
    chk("t2_one_chg", chg_seen - c0, 32'd1);

    // force_slow in dwell: immediate slow-down, then full dwell before 14 MHz
    force_slow = 1'b1;
    hc(1);
    chk("t3_slow_now", {30'd0, turbo_out}, 32'd0);
    force_slow = 1'b0;
    c0 = chg_seen;
    hc(DWELL);
    chk("t3_dwell_hold", {30'd0, turbo_out}, 32'd0);
    hc(1);
    chk("t3_back_14", {30'd0, turbo_out}, 32'd2);
    chk("t3_one_chg", chg_seen - c0, 32'd1);

    // stall generator at 14 MHz
    run_rows(0, seg_b);
`ifdef ZTURBO_STAT_EN
    chk("stat_to_two", {24'd0, stat_to}, 32'd2);
    chk("stat_stall_16", {16'd0, stat_stall}, 32'd16);
`endif
    run_rows(seg_b, seg_c);
`ifdef ZTURBO_STAT_EN
    chk("stat_to_clr", {24'd0, stat_to}, 32'd0);
    chk("stat_stall_clr", {16'd0, stat_stall}, 32'd0);
`endif

    // PEND cancel: 01 then 00 before any boundary
    do_reset();
    c0 = chg_seen;
    write_cfg(2'b01);
    write_cfg(2'b00);
    hc(2);
    chk("t4_cancel_turbo", {30'd0, turbo_out}, 32'd0);
    chk("t4_cancel_nochg", chg_seen - c0, 32'd0);

    // 7 MHz: no stalls
    write_cfg(2'b01);
    hc(2);
    chk("t5_at_7m", {30'd0, turbo_out}, 32'd1);
    run_rows(seg_c, seg_d);

    // randomized traffic against the model, with one mid-run reset
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst            = (i == 2000);
      pre_cend       = ($urandom_range(0, 2) == 0);
      cfg_we         = ($urandom_range(0, 24) == 0);
      cfg_turbo      = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 60) == 0) force_slow = ~force_slow;
      cpu_mreq_start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) vid_busy = ~vid_busy;
      stat_clr       = ($urandom_range(0, 300) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
